// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   - XLEN_DEFAULT : default operand/result width
//   - ALU_*        : 4-bit ALU selection codes, also imported by alu_control
//   - alu_state_e  : execute-unit FSM encoding (IDLE, SHIFT)
//   - is_shift()   : true for the iterative shift ops
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_LUI  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: combinational one-step shifter used by the SHIFT datapath.
//   value_i   [XLEN-1:0] value to shift
//   dist_i    [DW-1:0]   shift distance, never larger than SHIFT_STEP
//   kind_i    [3:0]      ALU_SLL, ALU_SRL or ALU_SRA (anything else passes through)
//   shifted_o [XLEN-1:0] shifted value; sra fills with the sign bit
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int SHIFT_STEP = 1,
  localparam int DW        = $clog2(SHIFT_STEP + 1)
) (
  input  logic [XLEN-1:0] value_i,
  input  logic [DW-1:0]   dist_i,
  input  logic [3:0]      kind_i,
  output logic [XLEN-1:0] shifted_o
);

  always_comb begin
    shifted_o = value_i;
    case (kind_i)
      ALU_SLL: shifted_o = value_i << dist_i;
      ALU_SRL: shifted_o = value_i >> dist_i;
      ALU_SRA: shifted_o = $signed(value_i) >>> dist_i;
      default: shifted_o = value_i;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage datapath with a registered result and zero flag.
// Arithmetic/logic ops (and shifts by 0) complete on the accept edge; shifts by
// N>0 iterate in the SHIFT state, moving at most SHIFT_STEP bits per cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               kills the in-flight shift and any pending result
//   in_valid/in_ready   operation handshake (alu_sel, op_a, op_b)
//   out_valid/out_ready result handshake (result, zero)
//   state_dbg           current FSM state, for observation only
// Optional build macro ALU_EXEC_FLAGS_EN adds registered neg, carry, ovf.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready does not depend on in_valid. Once out_valid rises, result and
// the flags stay stable until the edge where out_ready is high.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
`ifdef ALU_EXEC_FLAGS_EN
  output logic            neg,
  output logic            carry,
  output logic            ovf,
`endif
  output alu_state_e      state_dbg
);

  localparam int SW = $clog2(XLEN);            // shift-amount width
  localparam int DW = $clog2(SHIFT_STEP + 1);  // per-step distance width
  localparam logic [SW:0] STEP_W = (SW + 1)'(SHIFT_STEP);
  localparam int M = XLEN - 1;

  alu_state_e      state_q;
  logic [SW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q;
  logic [3:0]      kind_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            out_valid_q;

  logic [XLEN-1:0] alu_res_d;
  logic [SW-1:0]   amt;
  logic            accept;
  logic [DW-1:0]   step_dist;
  logic [SW:0]     cnt_d;
  logic [XLEN-1:0] step_out;

  assign amt      = op_b[SW-1:0];
  assign in_ready = !rst && !flush && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle result; shift codes land here only when the amount is 0.
  always_comb begin
    alu_res_d = '0;
    case (alu_sel)
      ALU_ADD:  alu_res_d = op_a + op_b;
      ALU_SUB:  alu_res_d = op_a - op_b;
      ALU_LUI:  alu_res_d = op_b;
      ALU_AND:  alu_res_d = op_a & op_b;
      ALU_OR:   alu_res_d = op_a | op_b;
      ALU_XOR:  alu_res_d = op_a ^ op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res_d = op_a;
      ALU_SLT:  alu_res_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  alu_res_d = '0;
    endcase
  end

`ifdef ALU_EXEC_FLAGS_EN
  logic carry_d, ovf_d, carry_q, ovf_q;

  // Add carries out exactly when the wrapped sum is below an addend.
  always_comb begin
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        carry_d = (alu_res_d < op_a);
        ovf_d   = (op_a[M] == op_b[M]) && (alu_res_d[M] != op_a[M]);
      end
      ALU_SUB: begin
        carry_d = (op_a >= op_b);
        ovf_d   = (op_a[M] != op_b[M]) && (alu_res_d[M] != op_a[M]);
      end
      default: ;
    endcase
  end

  assign neg   = result_q[M];
  assign carry = carry_q;
  assign ovf   = ovf_q;
`endif

  // Distance for this SHIFT cycle: min(SHIFT_STEP, remaining count).
  assign step_dist = ({1'b0, cnt_q} >= STEP_W) ? DW'(SHIFT_STEP) : DW'(cnt_q);
  assign cnt_d     = {1'b0, cnt_q} - (SW + 1)'(step_dist);

  alu_shift_step #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift_step (
    .value_i   (acc_q),
    .dist_i    (step_dist),
    .kind_i    (kind_q),
    .shifted_o (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      kind_q      <= ALU_SLL;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_EXEC_FLAGS_EN
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else if (flush) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // Consumption first; a load later in this block overrides it.
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift(alu_sel) && (amt != '0)) begin
              acc_q   <= op_a;
              cnt_q   <= amt;
              kind_q  <= alu_sel;
              state_q <= ST_SHIFT;
            end else begin
              result_q    <= alu_res_d;
              zero_q      <= (alu_res_d == '0);
              out_valid_q <= 1'b1;
`ifdef ALU_EXEC_FLAGS_EN
              carry_q     <= carry_d;
              ovf_q       <= ovf_d;
`endif
            end
          end
        end
        ST_SHIFT: begin
          acc_q <= step_out;
          cnt_q <= cnt_d[SW-1:0];
          if (cnt_d == '0) begin
            result_q    <= step_out;
            zero_q      <= (step_out == '0);
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
`ifdef ALU_EXEC_FLAGS_EN
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: self-checking bench for alu_exec_unit (XLEN=32).
// A transaction-level model (reference ALU + remaining-shift-cycle count +
// expected-result queue) is compared against the DUT on every falling edge;
// directed sequences pin the model with literal values. A second instance with
// SHIFT_STEP=4 is used for the multi-bit shift latency case.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int STEP = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a, op_b;
  logic        in_ready, out_valid, zero;
  logic [31:0] result;
  alu_state_e  state_dbg;

  logic        b_in_valid;
  logic [3:0]  b_alu_sel;
  logic [31:0] b_op_a, b_op_b;
  logic        b_in_ready, b_out_valid, b_zero;
  logic [31:0] b_result;
  alu_state_e  b_state;

`ifdef ALU_EXEC_FLAGS_EN
  logic neg, carry, ovf, b_neg, b_carry, b_ovf;
`endif

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero),
`ifdef ALU_EXEC_FLAGS_EN
    .neg(neg), .carry(carry), .ovf(ovf),
`endif
    .state_dbg(state_dbg)
  );

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .alu_sel(b_alu_sel), .op_a(b_op_a), .op_b(b_op_b),
    .out_valid(b_out_valid), .out_ready(1'b1),
    .result(b_result), .zero(b_zero),
`ifdef ALU_EXEC_FLAGS_EN
    .neg(b_neg), .carry(b_carry), .ovf(b_ovf),
`endif
    .state_dbg(b_state)
  );

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    n = b % 32;
    case (s)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0011: return b;
      4'b0101: return a & b;
      4'b0100: return a | b;
      4'b0111: return a ^ b;
      4'b1001: return a << n;
      4'b1000: return a >> n;
      4'b1010: return a[31] ? ~((~a) >> n) : (a >> n);
      4'b1101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1111: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_carry(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    t = {32'b0, a} + {32'b0, b};
    if (s == 4'b0000) return t[32];
    if (s == 4'b0001) return a >= b;
    return 1'b0;
  endfunction

  function automatic logic ref_ovf(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, full;
    logic [31:0] w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s == 4'b0000) full = sa + sb;
    else if (s == 4'b0001) full = sa - sb;
    else return 1'b0;
    w = full[31:0];
    return full != longint'($signed(w));
  endfunction

  function automatic int shift_cycles(input logic [3:0] s, input logic [31:0] b);
    int n;
    n = b % 32;
    if ((s == 4'b1001 || s == 4'b1000 || s == 4'b1010) && n > 0) return (n + STEP - 1) / STEP;
    return 0;
  endfunction

  logic [31:0] exp_q[$];
  int          m_busy = 0;
  logic        m_valid = 1'b0, m_known = 1'b0;
  logic [31:0] m_result = '0;
  logic        m_zero = 1'b0, m_carry = 1'b0, m_ovf = 1'b0;
  logic        m_rdy, chk_en = 1'b0;

  task automatic deliver(input logic c, input logic o);
    m_result = exp_q.pop_front();
    m_zero   = (m_result == 32'd0);
    m_carry  = c;
    m_ovf    = o;
    m_valid  = 1'b1;
    m_known  = 1'b1;
  endtask

  always @(posedge clk) begin
    m_rdy = !rst && !flush && (m_busy == 0) && (!m_valid || out_ready);
    if (rst) begin
      m_busy = 0; m_valid = 1'b0; m_known = 1'b1;
      m_result = '0; m_zero = 1'b0; m_carry = 1'b0; m_ovf = 1'b0;
      exp_q.delete();
    end else if (flush) begin
      m_busy = 0; m_valid = 1'b0; m_known = 1'b0;
      exp_q.delete();
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) deliver(1'b0, 1'b0);
      end else if (in_valid && m_rdy) begin
        exp_q.push_back(ref_alu(alu_sel, op_a, op_b));
        m_busy = shift_cycles(alu_sel, op_b);
        if (m_busy == 0) deliver(ref_carry(alu_sel, op_a, op_b), ref_ovf(alu_sel, op_a, op_b));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, !rst && !flush && (m_busy == 0) && (!m_valid || out_ready));
      check("out_valid", out_valid, m_valid);
      check("state", state_dbg, (m_busy > 0) ? ST_SHIFT : ST_IDLE);
      if (m_known) begin
        check("result", result, m_result);
        check("zero", zero, m_zero);
`ifdef ALU_EXEC_FLAGS_EN
        check("neg", neg, m_result[31]);
        check("carry", carry, m_carry);
        check("ovf", ovf, m_ovf);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                       input logic hold, output int waits);
    logic ok;
    ok = 1'b0;
    alu_sel = s; op_a = a; op_b = b; in_valid = 1'b1; waits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      waits++;
      if (ok) break;
    end
    check("issue_accept", ok, 1'b1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] r, input logic z);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_res"}, result, r);
    check({name, "_zero"}, zero, z);
    #1;
  endtask

  // Ends at the falling edge where out_valid is first seen.
  task automatic shift_wait(output int n, output logic rdy_seen);
    n = 0; rdy_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) rdy_seen = 1'b1;
      n++;
    end
  endtask

  logic [3:0] shift_codes[3] = '{4'b1001, 4'b1000, 4'b1010};
  logic [31:0] corner[5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};

  function automatic logic [31:0] rand_word();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int w, n;
    logic rs, ok;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_sel = 4'b0; op_a = '0; op_b = '0;
    b_in_valid = 1'b0; b_alu_sel = 4'b0; b_op_a = '0; b_op_b = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    alu_sel = 4'b0000; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'd0);
    check("rst_zero", zero, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;

    // add overflow, then back-to-back single-cycle ops
    issue(4'b0000, 32'h7FFF_FFFF, 32'd1, 1'b1, w);
    expect_out("add", 32'h8000_0000, 1'b0);
`ifdef ALU_EXEC_FLAGS_EN
    check("add_ovf", ovf, 1'b1);
    check("add_carry", carry, 1'b0);
    check("add_neg", neg, 1'b1);
`endif
    issue(4'b0001, 32'd5, 32'd5, 1'b1, w);
    check("b2b_sub_waits", w, 1);
    expect_out("sub", 32'd0, 1'b1);
    issue(4'b1101, 32'hFFFF_FFFF, 32'd1, 1'b1, w);
    check("b2b_slt_waits", w, 1);
    expect_out("slt", 32'd1, 1'b0);
    issue(4'b1111, 32'hFFFF_FFFF, 32'd1, 1'b0, w);
    check("b2b_sltu_waits", w, 1);
    expect_out("sltu", 32'd0, 1'b1);

    // sra by 31, one bit per cycle
    issue(4'b1010, 32'h8000_0000, 32'd31, 1'b0, w);
    shift_wait(n, rs);
    check("sra_latency", n, 31);
    check("sra_in_ready_low", rs, 1'b0);
    check("sra_res", result, 32'hFFFF_FFFF);
    #1;

    // same shift on the SHIFT_STEP=4 instance
    b_alu_sel = 4'b1010; b_op_a = 32'h8000_0000; b_op_b = 32'd31; b_in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); ok = b_in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    b_in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_out_valid) break;
      n++;
    end
    check("sra4_latency", n, 8);
    check("sra4_res", b_result, 32'hFFFF_FFFF);
    check("sra4_zero", b_zero, 1'b0);
    check("sra4_state", b_state, ST_IDLE);
`ifdef ALU_EXEC_FLAGS_EN
    check("sra4_carry", b_carry, 1'b0);
`endif
    #1;

    // sll with upper amount bits ignored, then output stall
    issue(4'b1001, 32'd1, 32'h24, 1'b0, w);
    out_ready = 1'b0;
    shift_wait(n, rs);
    check("sll_latency", n, 4);
    check("sll_res", result, 32'h10);
    #1;
    alu_sel = 4'b0000; op_a = 32'd100; op_b = 32'd23; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_res", result, 32'h10);
      check("stall_in_ready", in_ready, 1'b0);
    end
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("release_add", 32'd123, 1'b0);

    // flush on the third edge after a shift accept
    issue(4'b1000, 32'hF0, 32'd8, 1'b0, w);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); check("flush_pre_valid", out_valid, 1'b0);
      @(posedge clk); #1;
    end
    flush = 1'b1; alu_sel = 4'b0000; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_valid", out_valid, 1'b0);
    check("post_flush_state", state_dbg, ST_IDLE);
    check("post_flush_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); check("post_flush_quiet", out_valid, 1'b0);
    end
    #1;
    issue(4'b0000, 32'd2, 32'd3, 1'b0, w);
    expect_out("flush_add", 32'd5, 1'b0);

    // reset in the middle of a shift
    issue(4'b1010, 32'h1234_5678, 32'd20, 1'b0, w);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_res", result, 32'd0);
      check("midrst_zero", zero, 1'b0);
      check("midrst_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_in_ready", in_ready, 1'b1);
    #1;
    issue(4'b0110, 32'd7, 32'd9, 1'b0, w);
    expect_out("undef", 32'd0, 1'b1);

    // randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      alu_sel   = ($urandom_range(0, 2) == 0) ? shift_codes[$urandom_range(0, 2)] : 4'($urandom_range(0, 15));
      op_a      = rand_word();
      op_b      = ($urandom_range(0, 5) == 0) ? op_a : rand_word();
    end
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage datapath directly downstream of the ALU-control decoder.
- Consumes the 4-bit ALU selection code plus two XLEN operands and produces a registered result and a zero flag for branch resolution.
- Arithmetic and logic ops complete in one cycle.
- Shifts run iteratively over several cycles, so the block uses a valid/ready handshake on both sides, which lets the pipeline stall.

Parameters:
- XLEN, 32: operand and result width.
- SHIFT_STEP, 1: maximum shift distance applied per cycle. Must be a power of two, between 1 and XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kills any in-flight operation and any pending result.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an operation this cycle.
- alu_sel  in  4  ALU selection code.
- op_a  in  XLEN  operand A (rs1).
- op_b  in  XLEN  operand B (rs2 or immediate).
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  XLEN  registered result.
- zero  out  1  result == 0, registered with result.

Behaviour:
- Op codes:
  - 0000 add; 0001 sub.
  - 0011 pass B (lui).
  - 0101 and; 0100 or; 0111 xor.
  - 1001 sll; 1000 srl; 1010 sra.
  - 1101 slt (signed); 1111 sltu (unsigned). slt and sltu return 1 or 0, zero-extended.
  - Any other code gives result 0 and still completes.
- add and sub wrap modulo 2^XLEN. Shift amount is op_b[log2(XLEN)-1:0]; upper bits are ignored.
- Reset: state IDLE, out_valid=0, result=0, zero=0, shift counter 0. in_ready=0 while rst=1.
- in_ready = !rst && !flush && state==IDLE && (!out_valid || out_ready). An accept occurs when in_valid && in_ready.
- Non-shift op, or shift with amount 0: result, zero and out_valid=1 are loaded on the accept edge, so latency is 1 cycle. Throughput is 1 op per cycle when out_ready is held high.
- Shift with amount N>0 uses a two-state FSM, IDLE and SHIFT:
  - The accept edge loads acc=op_a and cnt=N, and goes to SHIFT.
  - Each SHIFT edge shifts acc by s=min(SHIFT_STEP,cnt) and sets cnt-=s.
  - sra fills with the sign bit; srl and sll fill with zeros.
  - On the edge where cnt reaches 0, the shifted value is loaded into result, zero is updated, out_valid goes to 1 and the FSM returns to IDLE.
  - Latency is ceil(N/SHIFT_STEP) cycles from accept to out_valid.
  - in_ready=0 throughout SHIFT.
- Output hold: while out_valid && !out_ready, result and zero are held stable. No new op is accepted while the output is stalled.
- flush=1 at an edge: state goes to IDLE, out_valid=0 and cnt=0. result and zero keep their values but are don't-care. No accept happens in a flush cycle, even if in_valid=1.
- rst has priority over flush. Reset mid-shift aborts the shift, with the same effect as flush plus result/zero cleared.
- Inputs are sampled only on the accept edge. Changes to op_a, op_b or alu_sel during SHIFT have no effect.

Optional Feature:
- Macro: ALU_EXEC_FLAGS_EN.
- Defined: adds outputs neg (result[XLEN-1]), carry and ovf. These are registered alongside result and hold under the same stall and flush rules.
  - For add: carry is the carry-out and ovf is signed overflow.
  - For sub: carry = no-borrow (A>=B unsigned) and ovf is signed overflow.
  - For all other ops: carry=0 and ovf=0.
  - All three reset to 0.
- Undefined: these ports and registers do not exist. Only zero is provided.

Decomposition:
- Package alu_pkg holds:
  - 4-bit localparams for every op code.
  - The FSM state encoding (IDLE, SHIFT).
  - The XLEN default.
- The alu_control decoder imports the same op-code constants.
- Sub-module alu_shift_step: a combinational one-step shifter. Inputs are value, distance (at most SHIFT_STEP), and kind (sll, srl or sra); output is the shifted value. It is instantiated once for the SHIFT datapath.

Test Plan:
- add, A=0x7FFFFFFF, B=1, out_ready=1 -> out_valid after 1 cycle; result=0x80000000, zero=0. With flags: ovf=1, carry=0.
- sub, A=5, B=5 -> result=0, zero=1. Then slt, A=0xFFFFFFFF, B=1 -> result=1. Then sltu with the same operands -> result=0. Run back-to-back with in_valid held high, checking 1 op/cycle.
- sra, A=0x80000000, B=31, SHIFT_STEP=1 -> in_ready=0 for 31 cycles, out_valid on the 31st cycle after accept, result=0xFFFFFFFF. Repeat with SHIFT_STEP=4 -> latency 8.
- sll, A=1, B=0x24 (amount 4) -> latency 4, result=0x10. Hold out_ready=0 for 3 cycles -> result stable, in_ready=0. Then out_ready=1 together with a new add accepted in the same cycle.
- srl, A=0xF0, B=8; assert flush 3 cycles after accept -> out_valid never rises; the FSM is IDLE and in_ready=1 on the next cycle; a following add 2+3 gives result=5.
- rst asserted mid-shift -> next cycle out_valid=0, result=0, zero=0, and in_ready=0 until rst deasserts. Undefined code 0110 -> result=0, zero=1.
